// File: rtl/cordic_spi_host.sv
// cordic_spi_host: SPI master (mode 0) front end for a CORDIC SPI slave.
// A request captures four 16-bit operands, sends them as an 8-byte write
// frame (low byte first, each byte MSB first), waits for data_ready, then
// reads sin, cos and alpha back in a 6-byte frame.
// Ports:
//   i_clk, rst_n          clock, synchronous active-low reset
//   i_start               request, sampled only in IDLE
//   i_x/i_y/i_alpha/i_atan_0  operands, captured on accepted start
//   o_busy                high from accepted start until back in IDLE
//   o_sin/o_cos/o_alpha   result registers, updated with o_valid
//   o_valid, o_timeout    one-cycle pulses
//   sclk, mosi, cs_n      SPI master outputs (sclk idles low, cs_n high)
//   miso, data_ready      slave inputs, both double-flop synchronized
module cordic_spi_host #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned BYTE_GAP = 8,
  parameter int unsigned CS_GAP   = 4,
  parameter int unsigned TIMEOUT  = 1023
) (
  input  logic        i_clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic [15:0] i_x,
  input  logic [15:0] i_y,
  input  logic [15:0] i_alpha,
  input  logic [15:0] i_atan_0,
  output logic        o_busy,
  output logic [15:0] o_sin,
  output logic [15:0] o_cos,
  output logic [15:0] o_alpha,
  output logic        o_valid,
  output logic        o_timeout,
  output logic        sclk,
  output logic        mosi,
  output logic        cs_n,
  input  logic        miso,
  input  logic        data_ready
);

  typedef enum logic [2:0] {
    IDLE, WR_SETUP, WR_BYTES, WR_GAP, WAIT_RDY, RD_SETUP, RD_BYTES, RD_END
  } state_t;

  state_t state, state_nx;

  logic [1:0]  miso_sync, rdy_sync;
  logic        miso_s, rdy_s;
  logic [31:0] cnt;
  logic        in_gap;
  logic [2:0]  bit_cnt, byte_cnt;
  logic [63:0] tx_sr;
  logic [47:0] rx_sr;
  logic [1:0]  rise_d;

  logic       in_bytes, half_done, gap_done, rise_now, byte_end, frame_end;
  logic       setup_done, wr_gap_done, rdy_timeout, end_done;
  logic [2:0] last_byte;

  assign miso_s = miso_sync[1];
  assign rdy_s  = rdy_sync[1];
  // tx_sr shifts in zeros, so mosi is 0 once the write frame has gone out
  assign mosi   = tx_sr[63];

  always_comb begin
    in_bytes    = (state == WR_BYTES) || (state == RD_BYTES);
    last_byte   = (state == WR_BYTES) ? 3'd7 : 3'd5;
    half_done   = in_bytes && !in_gap && (cnt == CLK_DIV - 1);
    gap_done    = in_bytes && in_gap && (cnt == BYTE_GAP - 1);
    rise_now    = half_done && !sclk;
    byte_end    = half_done && sclk && (bit_cnt == 3'd7);
    frame_end   = byte_end && (byte_cnt == last_byte);
    setup_done  = (cnt == CS_GAP - 1);
    wr_gap_done = (cnt == CLK_DIV + CS_GAP - 1);
    rdy_timeout = (cnt == TIMEOUT - 1);
    end_done    = (cnt == CS_GAP);
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (i_start) state_nx = WR_SETUP;
      WR_SETUP: if (setup_done) state_nx = WR_BYTES;
      WR_BYTES: if (frame_end) state_nx = WR_GAP;
      WR_GAP:   if (wr_gap_done) state_nx = WAIT_RDY;
      WAIT_RDY: begin
        if (rdy_s) state_nx = RD_SETUP;
        else if (rdy_timeout) state_nx = IDLE;
      end
      RD_SETUP: if (setup_done) state_nx = RD_BYTES;
      RD_BYTES: if (frame_end) state_nx = RD_END;
      RD_END:   if (end_done) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge i_clk) begin
    if (!rst_n) begin
      miso_sync <= '0;
      rdy_sync  <= '0;
      cnt       <= '0;
      in_gap    <= 1'b0;
      bit_cnt   <= '0;
      byte_cnt  <= '0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      rise_d    <= '0;
      sclk      <= 1'b0;
      cs_n      <= 1'b1;
      o_busy    <= 1'b0;
      o_valid   <= 1'b0;
      o_timeout <= 1'b0;
      o_sin     <= '0;
      o_cos     <= '0;
      o_alpha   <= '0;
    end else begin
      miso_sync <= {miso_sync[0], miso};
      rdy_sync  <= {rdy_sync[0], data_ready};
      o_valid   <= 1'b0;
      o_timeout <= 1'b0;
      // Sample two cycles after the rising edge: the synchronizer output
      // then holds exactly the miso level present at the edge.
      rise_d    <= {rise_d[0], rise_now};
      if (rise_d[1]) rx_sr <= {rx_sr[46:0], miso_s};

      case (state)
        IDLE: begin
          cnt <= '0;
          if (i_start) begin
            tx_sr  <= {i_x[7:0], i_x[15:8], i_y[7:0], i_y[15:8],
                       i_alpha[7:0], i_alpha[15:8], i_atan_0[7:0], i_atan_0[15:8]};
            cs_n   <= 1'b0;
            o_busy <= 1'b1;
          end
        end
        WR_SETUP, RD_SETUP: begin
          in_gap   <= 1'b0;
          bit_cnt  <= '0;
          byte_cnt <= '0;
          cnt      <= setup_done ? '0 : cnt + 32'd1;
        end
        WR_BYTES, RD_BYTES: begin
          if (in_gap) begin
            if (gap_done) begin
              in_gap <= 1'b0;
              cnt    <= '0;
            end else begin
              cnt <= cnt + 32'd1;
            end
          end else if (half_done) begin
            cnt  <= '0;
            sclk <= !sclk;
            if (sclk) begin
              tx_sr   <= {tx_sr[62:0], 1'b0};
              bit_cnt <= bit_cnt + 3'd1;
              if (byte_end) begin
                byte_cnt <= byte_cnt + 3'd1;
                in_gap   <= !frame_end;
              end
            end
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        WR_GAP: begin
          if (cnt == CLK_DIV - 1) cs_n <= 1'b1;
          cnt <= wr_gap_done ? '0 : cnt + 32'd1;
        end
        WAIT_RDY: begin
          if (rdy_s) begin
            cs_n <= 1'b0;
            cnt  <= '0;
          end else if (rdy_timeout) begin
            o_timeout <= 1'b1;
            o_busy    <= 1'b0;
            cnt       <= '0;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        RD_END: begin
          // First RD_END cycle: the last miso sample has landed by now.
          if (cnt == 32'd0) begin
            cs_n    <= 1'b1;
            o_sin   <= {rx_sr[39:32], rx_sr[47:40]};
            o_cos   <= {rx_sr[23:16], rx_sr[31:24]};
            o_alpha <= {rx_sr[7:0],   rx_sr[15:8]};
            o_valid <= 1'b1;
          end
          if (end_done) begin
            o_busy <= 1'b0;
            cnt    <= '0;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule
